vslc_sevseg_scan: RTL and testbench

- Downstream display stage for the iCEBreaker build of the VSLC core.
- Takes an 8-bit value from the core's output byte and shows it as two hex digits on the dual-digit 7-segment PMOD.
- The PMOD shares one set of segment lines between both digits and selects the digit with one pin, so this block time-multiplexes the two digits.
- It inserts blanking gaps between digits to suppress ghosting, and double-buffers the value so a frame never shows a torn update.

---
 rtl/vslc_sevseg_pkg.sv | 22 ++
 rtl/vslc_sevseg_scan_hex_decode.sv | 11 +
 rtl/vslc_sevseg_scan.sv | 108 ++++++++++
 tb/tb_vslc_sevseg_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vslc_sevseg_pkg.sv
// Shared definitions for the dual-digit 7-segment scanner: state encoding,
// active-high hex segment table and the polarity-dependent "all off" pattern.
package vslc_sevseg_pkg;

  typedef enum logic [1:0] {
    SHOW_D0 = 2'd0,
    BLANK0  = 2'd1,
    SHOW_D1 = 2'd2,
    BLANK1  = 2'd3
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a set bit lights the segment.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] SEG_OFF(input logic active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

endpackage

// File: rtl/vslc_sevseg_scan_hex_decode.sv
// Combinational nibble to active-high 7-segment decoder.
module vslc_sevseg_hex_decode
  import vslc_sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/vslc_sevseg_scan.sv
// Two-digit multiplexed hex display driver with blanking gaps and a frame-aligned
// double buffer. Define VSLC_SEVSEG_LZB_EN to blank a leading-zero digit 1.
module vslc_sevseg_scan
  import vslc_sevseg_pkg::*;
#(
  parameter int SCAN_DIV     = 15,
  parameter int BLANK_CYCLES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic [1:0] dp_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic       dp,
  output logic       digit_sel,
  output logic       frame_start
);

  localparam logic                POL        = (ACTIVE_LOW != 0);
  localparam logic [SCAN_DIV-1:0] SHOW_LAST  = '1;
  localparam logic [SCAN_DIV-1:0] BLANK_LAST = SCAN_DIV'(BLANK_CYCLES - 1);

  state_t              state, nxt;
  logic [SCAN_DIV-1:0] cnt;
  logic [7:0]          shadow, display, disp_next;
  logic [1:0]          shadow_dp, disp_dp, disp_dp_next;
  logic                frame_edge;
  logic [3:0]          nib;
  logic [6:0]          raw, seg_next;
  logic                dp_next, sel_next;

  vslc_sevseg_hex_decode u_dec (
    .nibble (nib),
    .seg    (raw)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      SHOW_D0: if (cnt == SHOW_LAST)  nxt = BLANK0;
      BLANK0:  if (cnt == BLANK_LAST) nxt = SHOW_D1;
      SHOW_D1: if (cnt == SHOW_LAST)  nxt = BLANK1;
      BLANK1:  if (cnt == BLANK_LAST) nxt = SHOW_D0;
      default: nxt = BLANK1;
    endcase

    // Outputs are registered from the next state, so the value latched on
    // the frame edge must be forwarded straight from the shadow.
    frame_edge   = (state == BLANK1) && (nxt == SHOW_D0);
    disp_next    = frame_edge ? shadow    : display;
    disp_dp_next = frame_edge ? shadow_dp : disp_dp;
    nib          = (nxt == SHOW_D1) ? disp_next[7:4] : disp_next[3:0];

    seg_next = SEG_OFF(POL);
    dp_next  = POL;
    sel_next = digit_sel;
    unique case (nxt)
      SHOW_D0: begin
        seg_next = raw ^ {7{POL}};
        dp_next  = disp_dp_next[0] ^ POL;
        sel_next = 1'b0;
      end
      SHOW_D1: begin
        seg_next = raw ^ {7{POL}};
        dp_next  = disp_dp_next[1] ^ POL;
        sel_next = 1'b1;
`ifdef VSLC_SEVSEG_LZB_EN
        if (disp_next[7:4] == 4'h0 && !disp_dp_next[1]) begin
          seg_next = SEG_OFF(POL);
          dp_next  = POL;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK1;
      cnt         <= '0;
      seg         <= SEG_OFF(POL);
      dp          <= POL;
      digit_sel   <= 1'b0;
      frame_start <= 1'b0;
      shadow      <= '0;
      shadow_dp   <= '0;
      display     <= '0;
      disp_dp     <= '0;
    end else begin
      state       <= nxt;
      cnt         <= (nxt != state) ? '0 : cnt + 1'b1;
      seg         <= seg_next;
      dp          <= dp_next;
      digit_sel   <= sel_next;
      frame_start <= frame_edge;
      display     <= disp_next;
      disp_dp     <= disp_dp_next;
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_vslc_sevseg_scan.sv
// Scoreboard bench for vslc_sevseg_scan: frame-position reference model feeds
// an expectation queue drained by a per-cycle output monitor.
module tb_vslc_sevseg_scan;

  localparam int S_DIV = 2;
  localparam int BLK   = 2;
  localparam int AL    = 0;
  localparam int S     = 1 << S_DIV;
  localparam int F     = 2 * (S + BLK);
  localparam bit POL   = (AL != 0);

  localparam logic [6:0] TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] value = '0;
  logic [1:0] dp_in = '0;
  logic [6:0] seg;
  logic       dp, digit_sel, frame_start;

  always #5 clk = ~clk;

  vslc_sevseg_scan #(
    .SCAN_DIV     (S_DIV),
    .BLANK_CYCLES (BLK),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic       sel;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: c counts edges since the reset edge; the first SHOW_D0
  // starts BLK edges after it, and from then on everything repeats every F.
  int         c = 0;
  logic [7:0] m_shadow = '0, m_disp = '0;
  logic [1:0] m_sdp = '0, m_ddp = '0;
  logic       m_sel = 1'b0;

  function automatic logic [6:0] lit(input logic [6:0] a);
    return POL ? ~a : a;
  endfunction

  function automatic int pos_next();
    return (c + 1 + F - BLK) % F;
  endfunction

  task automatic step(input logic r, input logic l, input logic [7:0] v, input logic [1:0] d);
    exp_t e;
    int   pos;
    rst = r; load = l; value = v; dp_in = d;
    @(posedge clk);
    e.seg = lit(7'h00);
    e.dp  = POL;
    e.fs  = 1'b0;
    if (r) begin
      c = 0; m_shadow = '0; m_sdp = '0; m_disp = '0; m_ddp = '0; m_sel = 1'b0;
    end else begin
      c++;
      pos = (c + F - BLK) % F;
      if (pos == 0) begin
        m_disp = m_shadow;
        m_ddp  = m_sdp;
      end
      if (l) begin
        m_shadow = v;
        m_sdp    = d;
      end
      e.fs = (pos == 0);
      if (pos < S) begin
        m_sel = 1'b0;
        e.seg = lit(TAB[m_disp[3:0]]);
        e.dp  = m_ddp[0] ^ POL;
      end else if (pos >= S + BLK && pos < 2 * S + BLK) begin
        m_sel = 1'b1;
        e.seg = lit(TAB[m_disp[7:4]]);
        e.dp  = m_ddp[1] ^ POL;
`ifdef VSLC_SEVSEG_LZB_EN
        if (m_disp[7:4] == 4'h0 && !m_ddp[1]) begin
          e.seg = lit(7'h00);
          e.dp  = POL;
        end
`endif
      end
    end
    e.sel = m_sel;
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 2'($urandom));
  endtask

  task automatic align(input int target);
    for (int i = 0; i < F && pos_next() != target; i++) idle(1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if ({seg, dp, digit_sel, frame_start} !== e) begin
          miscompares++;
          $display("FAIL out[%0d] t=%0t: got seg=%h dp=%b sel=%b fs=%b, want seg=%h dp=%b sel=%b fs=%b",
                   vectors, $time, seg, dp, digit_sel, frame_start, e.seg, e.dp, e.sel, e.fs);
        end
      end
    end
  end

  initial begin : stimulus
    step(1'b1, 1'b0, 8'h00, 2'b00);
    step(1'b1, 1'b1, 8'h99, 2'b11);
    idle(14);

    align(5);
    step(1'b0, 1'b1, 8'hA5, 2'b10);
    idle(26);

    align(3);
    step(1'b0, 1'b1, 8'h12, 2'b00);
    idle(2);
    step(1'b0, 1'b1, 8'h34, 2'b00);
    idle(24);

    align(0);
    step(1'b0, 1'b1, 8'h5C, 2'b01);
    idle(26);

    step(1'b0, 1'b1, 8'hFF, 2'b11);
    idle(24);
    align(S + BLK + 1);
    step(1'b1, 1'b0, 8'h00, 2'b00);
    idle(16);

    step(1'b0, 1'b1, 8'h07, 2'b00);
    idle(24);
    step(1'b0, 1'b1, 8'h17, 2'b00);
    idle(24);
    step(1'b0, 1'b1, 8'h0B, 2'b10);
    idle(24);

    repeat (1500)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 8'($urandom), 2'($urandom));

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d outputs still pending, want 0", q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
